// File: rtl/onehot_mux_chk.sv
// One-hot AND-OR read-data mux with multi-hot select detection and a sticky error flag.
// Define ONEHOT_MUX_REG_OUT_EN to register `out` (1-cycle latency, resets to 0).
module onehot_mux_chk #(
  parameter int N_INPUTS = 2,
  parameter int W_INPUT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INPUTS*W_INPUT-1:0]   in,
  input  logic [N_INPUTS-1:0]           sel,
  input  logic                          err_clr,
  output logic [W_INPUT-1:0]            out,
  output logic                          sel_any,
  output logic                          sel_multi,
  output logic                          sel_err
);

  logic [W_INPUT-1:0] mux_data;
  logic               seen;
  logic               multi;

  // Pure AND-OR: an all-zero select yields zero, a multi-hot select ORs its lanes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mux_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      mux_data = mux_data | (in[i*W_INPUT +: W_INPUT] & {W_INPUT{sel[i]}});
    end
  end

  // Multi-hot: some bit is set after an earlier bit was already set.
  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      multi = multi | (seen & sel[i]);
      seen  = seen | sel[i];
    end
  end

  assign sel_any   = |sel;
  assign sel_multi = multi;

  // Set has priority over clear so a fault seen in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (sel_multi) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

`ifdef ONEHOT_MUX_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= mux_data;
    end
  end
`else
  assign out = mux_data;
`endif

endmodule

// File: tb/tb_onehot_mux_chk.sv
// Self-checking bench for onehot_mux_chk: N=2 table vectors plus N=4 error-flag sequences.
module tb_onehot_mux_chk;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         err_clr;
  logic [63:0]  in2;
  logic [1:0]   sel2;
  logic [127:0] in4;
  logic [3:0]   sel4;
  logic [31:0]  out2, out4;
  logic         any2, multi2, err2;
  logic         any4, multi4, err4;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          dut;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [31:0] prev_out [2];

  typedef struct {
    logic [31:0] lane1;
    logic [31:0] lane0;
    logic [1:0]  sel;
    logic [31:0] exp_out;
    logic        exp_any;
    logic        exp_multi;
    logic        err_before;
    logic        err_after;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  onehot_mux_chk #(.N_INPUTS(2), .W_INPUT(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel2), .err_clr(err_clr),
    .out(out2), .sel_any(any2), .sel_multi(multi2), .sel_err(err2)
  );

  onehot_mux_chk #(.N_INPUTS(4), .W_INPUT(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4), .err_clr(err_clr),
    .out(out4), .sel_any(any4), .sel_multi(multi4), .sel_err(err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input string name);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, (e.dut == 0) ? out2 : out4, e.exp);
      prev_out[e.dut] = e.exp;
    end
  endtask

  // Drives one vector for one edge; flags and pre-edge sel_err at the first negedge,
  // post-edge sel_err at the following negedge; out where its latency puts it.
  task automatic apply(input int dut, input logic [127:0] lanes, input logic [3:0] s,
                       input logic [31:0] e_out, input logic e_any, input logic e_multi,
                       input logic e_eb, input logic e_ea, input logic clr, input string name);
    @(posedge clk);
    #1;
    if (dut == 0) begin
      in2  = lanes[63:0];
      sel2 = s[1:0];
    end else begin
      in4  = lanes;
      sel4 = s;
    end
    err_clr = clr;
    sb_q.push_back('{dut: dut, exp: e_out});
    @(negedge clk);
    check({name, ".sel_any"},    {31'd0, (dut == 0) ? any2 : any4},     {31'd0, e_any});
    check({name, ".sel_multi"},  {31'd0, (dut == 0) ? multi2 : multi4}, {31'd0, e_multi});
    check({name, ".err_before"}, {31'd0, (dut == 0) ? err2 : err4},     {31'd0, e_eb});
`ifdef ONEHOT_MUX_REG_OUT_EN
    check({name, ".out_hold"}, (dut == 0) ? out2 : out4, prev_out[dut]);
    @(posedge clk);
    @(negedge clk);
    sb_compare({name, ".out"});
`else
    sb_compare({name, ".out"});
    @(posedge clk);
    @(negedge clk);
`endif
    check({name, ".err_after"}, {31'd0, (dut == 0) ? err2 : err4}, {31'd0, e_ea});
  endtask

  localparam logic [127:0] LANES4 = {32'h8, 32'h4, 32'h2, 32'h1};

  initial begin
    vecs[0] = '{32'hDEADBEEF, 32'h12345678, 2'b01, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hDEADBEEF, 32'h12345678, 2'b10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hCAFEF00D, 32'h0BADC0DE, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h5A5A0000, 32'hA5A5A5A5, 2'b01, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000FF00, 32'h000000F0, 2'b11, 32'h0000FFF0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n   = 1'b0;
    err_clr = 1'b0;
    in2     = '0;
    sel2    = '0;
    in4     = '0;
    sel4    = '0;
    prev_out[0] = '0;
    prev_out[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.err2", {31'd0, err2}, 32'd0);
    check("reset.err4", {31'd0, err4}, 32'd0);
    check("reset.out2", out2, 32'd0);
    check("reset.out4", out4, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply(0, {64'd0, vecs[i].lane1, vecs[i].lane0}, {2'b00, vecs[i].sel}, vecs[i].exp_out,
            vecs[i].exp_any, vecs[i].exp_multi, vecs[i].err_before, vecs[i].err_after,
            1'b0, $sformatf("n2_vec%0d", i));
    end
    @(negedge clk);
    sel2 = 2'b00;

    apply(1, LANES4, 4'b0101, 32'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "n4_multi_set");
    apply(1, LANES4, 4'b0001, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "n4_sticky");
    apply(1, LANES4, 4'b0010, 32'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "n4_clear");
    apply(1, LANES4, 4'b0101, 32'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "n4_reset_err");
    apply(1, LANES4, 4'b0011, 32'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "n4_set_wins");
    apply(1, LANES4, 4'b1111, 32'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "n4_all_hot");
    apply(1, LANES4, 4'b1000, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "n4_lane3");

    // Mid-operation reset while the select is multi-hot.
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    err_clr = 1'b0;
    sel4    = 4'b0011;
    @(negedge clk);
    check("rst_mid.multi_comb", {31'd0, multi4}, 32'd1);
    check("rst_mid.err_before", {31'd0, err4}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.err_after", {31'd0, err4}, 32'd0);
`ifdef ONEHOT_MUX_REG_OUT_EN
    check("rst_mid.out", out4, 32'd0);
    prev_out[1] = '0;
`else
    check("rst_mid.out", out4, 32'h3);
`endif
    rst_n = 1'b1;
    sel4  = 4'b0000;

    apply(1, LANES4, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "n4_idle");

    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
